// File: rtl/mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 operation
// selects, OP/MULDIV instruction identification and FSM state constants.
package mdu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic logic f3_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   function automatic logic f3_is_rem(input logic [2:0] f3);
      return f3[2] & f3[1];
   endfunction

endpackage

// File: rtl/mdu_iter_datapath.sv
// Iterative multiply/divide datapath: one shift-add or one restoring
// subtract-shift step per enabled cycle on unsigned magnitudes.
module mdu_iter_datapath #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      cpu_clk,
   input  logic                      cpu_rst,
   input  logic                      load,
   input  logic                      step,
   input  logic                      is_div,
   input  logic [DATA_WIDTH-1:0]     a_mag,
   input  logic [DATA_WIDTH-1:0]     b_mag,
   output logic [2*DATA_WIDTH-1:0]   acc_nxt,
   output logic                      mplr_last
);

   logic [2*DATA_WIDTH-1:0] acc;
   logic [2*DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0]   mplr;
   logic [DATA_WIDTH:0]     rshift;
   logic [DATA_WIDTH:0]     diff;

   // Divide keeps {remainder, quotient} in acc; the quotient bits shift in from the bottom.
   always_comb begin
      rshift    = acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
      diff      = rshift - {1'b0, mcand[DATA_WIDTH-1:0]};
      mplr_last = (mplr[DATA_WIDTH-1:1] == '0);
      acc_nxt   = acc;
      if (is_div) begin
         acc_nxt = {(diff[DATA_WIDTH] ? rshift[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0]),
                    acc[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
      end else if (mplr[0]) begin
         acc_nxt = acc + mcand;
      end
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         acc   <= '0;
         mcand <= '0;
         mplr  <= '0;
      end else if (load) begin
         acc   <= is_div ? {{DATA_WIDTH{1'b0}}, a_mag} : '0;
         mcand <= {{DATA_WIDTH{1'b0}}, (is_div ? b_mag : a_mag)};
         mplr  <= is_div ? '0 : b_mag;
      end else if (step) begin
         acc <= acc_nxt;
         if (!is_div) begin
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M multiply/divide unit: FSM, stall, sign fix-up and
// special division cases. Optional multiply early-out via MDU_EARLY_OUT_EN.
module ex_muldiv_unit
   import mdu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rst,
   input  logic                  flush_i,
   input  logic                  start_i,
   input  logic [2:0]            funct3_i,
   input  logic [DATA_WIDTH-1:0] rs1_val_i,
   input  logic [DATA_WIDTH-1:0] rs2_val_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o
);

`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY_OUT = 1'b1;
`else
   localparam bit EARLY_OUT = 1'b0;
`endif

   localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [1:0]              state;
   logic [CNT_WIDTH-1:0]    cnt;
   logic [2:0]              f3_q;
   logic                    res_neg;

   logic                    accept;
   logic                    in_div, in_rem;
   logic                    rs1_signed, rs2_signed;
   logic                    a_neg, b_neg;
   logic [DATA_WIDTH-1:0]   a_mag, b_mag;
   logic                    div_zero, div_ovf, mul_zero, shortcut;
   logic [DATA_WIDTH-1:0]   short_res;
   logic                    dp_is_div;
   logic [2*DATA_WIDTH-1:0] acc_nxt;
   logic [2*DATA_WIDTH-1:0] prod;
   logic                    mplr_last;
   logic                    last;
   logic [DATA_WIDTH-1:0]   calc_res;

   always_comb begin
      accept     = (state == ST_IDLE) & start_i & ~flush_i;
      in_div     = f3_is_div(funct3_i);
      in_rem     = f3_is_rem(funct3_i);
      rs1_signed = (funct3_i == F3_MULH) | (funct3_i == F3_MULHSU) |
                   (funct3_i == F3_DIV)  | (funct3_i == F3_REM);
      rs2_signed = (funct3_i == F3_MULH) | (funct3_i == F3_DIV) | (funct3_i == F3_REM);
      a_neg      = rs1_signed & rs1_val_i[DATA_WIDTH-1];
      b_neg      = rs2_signed & rs2_val_i[DATA_WIDTH-1];
      a_mag      = a_neg ? -rs1_val_i : rs1_val_i;
      b_mag      = b_neg ? -rs2_val_i : rs2_val_i;
      div_zero   = in_div & (rs2_val_i == '0);
      div_ovf    = in_div & ~funct3_i[0] & (rs1_val_i == MIN_NEG) & (rs2_val_i == '1);
      mul_zero   = EARLY_OUT & ~in_div & (rs2_val_i == '0);
      shortcut   = div_zero | div_ovf | mul_zero;
      if (mul_zero)      short_res = '0;
      else if (div_zero) short_res = in_rem ? rs1_val_i : '1;
      else               short_res = in_rem ? '0 : MIN_NEG;
      dp_is_div  = (state == ST_IDLE) ? in_div : f3_is_div(f3_q);
   end

   mdu_iter_datapath #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_datapath (
      .cpu_clk  (cpu_clk),
      .cpu_rst  (cpu_rst),
      .load     (accept),
      .step     (state == ST_CALC),
      .is_div   (dp_is_div),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .acc_nxt  (acc_nxt),
      .mplr_last(mplr_last)
   );

   // Multiply sign fix-up negates the full double-width product before picking the half.
   always_comb begin
      prod = res_neg ? -acc_nxt : acc_nxt;
      case (f3_q)
         F3_MUL:                     calc_res = prod[DATA_WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         F3_DIV, F3_DIVU:            calc_res = res_neg ? -acc_nxt[DATA_WIDTH-1:0]
                                                        :  acc_nxt[DATA_WIDTH-1:0];
         default:                    calc_res = res_neg ? -acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH]
                                                        :  acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
      endcase
      last = (cnt == CNT_WIDTH'(DATA_WIDTH-1)) |
             (EARLY_OUT & ~f3_is_div(f3_q) & mplr_last);
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         res_neg  <= 1'b0;
         result_o <= '0;
      end else if (flush_i) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  f3_q    <= funct3_i;
                  cnt     <= '0;
                  res_neg <= in_rem ? a_neg : (a_neg ^ b_neg);
                  if (shortcut) begin
                     result_o <= short_res;
                     state    <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  result_o <= calc_res;
                  state    <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stall_o = ~cpu_rst & (accept | (state == ST_CALC));
   assign busy_o  = (state != ST_IDLE);
   assign done_o  = (state == ST_DONE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (honours MDU_EARLY_OUT_EN).
module tb_ex_muldiv_unit;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic        flush_i;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_val_i;
   logic [31:0] rs2_val_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;

   int tests = 0;
   int fails = 0;

`ifdef MDU_EARLY_OUT_EN
   localparam int STALL_MUL53 = 3;
   localparam int STALL_MUL0  = 1;
`else
   localparam int STALL_MUL53 = 33;
   localparam int STALL_MUL0  = 33;
`endif

   always #5 cpu_clk = ~cpu_clk;

   ex_muldiv_unit #(
      .DATA_WIDTH(32),
      .CNT_WIDTH (6)
   ) dut (
      .cpu_clk  (cpu_clk),
      .cpu_rst  (cpu_rst),
      .flush_i  (flush_i),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .rs1_val_i(rs1_val_i),
      .rs2_val_i(rs2_val_i),
      .stall_o  (stall_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Holds start_i until done_o is seen, then watches two more cycles.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output int dones);
      bit seen;
      res    = 'x;
      stalls = 0;
      dones  = 0;
      seen   = 1'b0;
      @(posedge cpu_clk); #1;
      funct3_i  = f3;
      rs1_val_i = a;
      rs2_val_i = b;
      start_i   = 1'b1;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge cpu_clk);
         if (stall_o) stalls++;
         if (done_o) begin
            dones++;
            res     = result_o;
            seen    = 1'b1;
            start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      repeat (2) begin
         @(negedge cpu_clk);
         if (stall_o) stalls++;
         if (done_o)  dones++;
      end
   endtask

   logic [31:0] r;
   int          st, dn, late_done;

   initial begin
      cpu_rst   = 1'b1;
      flush_i   = 1'b0;
      start_i   = 1'b1;
      funct3_i  = 3'b000;
      rs1_val_i = 32'd3;
      rs2_val_i = 32'd4;
      #3;
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_busy",  {31'd0, busy_o},  32'd0);
      check("rst_done",  {31'd0, done_o},  32'd0);
      check("rst_result", result_o, 32'd0);
      start_i = 1'b0;
      @(negedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst = 1'b0;

      do_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, st, dn);
      check("mul_res", r, 32'hFFFF_FFEB);
      check("mul_stall", st, 33);
      check("mul_done", dn, 1);

      do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, st, dn);
      check("mulhu_res", r, 32'hFFFF_FFFE);
      check("mulhu_done", dn, 1);
      do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, st, dn);
      check("mulh_res", r, 32'h0000_0000);
      do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, st, dn);
      check("mulhsu_res", r, 32'hFFFF_FFFF);
      do_op(3'b001, 32'h8000_0000, 32'h8000_0000, r, st, dn);
      check("mulh_minneg", r, 32'h4000_0000);

      do_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, st, dn);
      check("div_res", r, 32'hFFFF_FFFD);
      check("div_stall", st, 33);
      do_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, st, dn);
      check("rem_res", r, 32'hFFFF_FFFF);
      do_op(3'b101, 32'd100, 32'd7, r, st, dn);
      check("divu_res", r, 32'd14);
      do_op(3'b111, 32'd100, 32'd7, r, st, dn);
      check("remu_res", r, 32'd2);
      do_op(3'b100, 32'd7, 32'hFFFF_FFFE, r, st, dn);
      check("div_pos_neg", r, 32'hFFFF_FFFD);

      do_op(3'b100, 32'd5, 32'd0, r, st, dn);
      check("div0_res", r, 32'hFFFF_FFFF);
      check("div0_stall", st, 1);
      check("div0_done", dn, 1);
      do_op(3'b110, 32'd5, 32'd0, r, st, dn);
      check("rem0_res", r, 32'd5);
      check("rem0_stall", st, 1);
      do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, st, dn);
      check("divovf_res", r, 32'h8000_0000);
      check("divovf_stall", st, 1);
      do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, st, dn);
      check("removf_res", r, 32'd0);
      do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, r, st, dn);
      check("divu_big", r, 32'd0);
      check("divu_big_stall", st, 33);

      do_op(3'b000, 32'd5, 32'd3, r, st, dn);
      check("mul53_res", r, 32'd15);
      check("mul53_stall", st, STALL_MUL53);
      do_op(3'b000, 32'd1234, 32'd0, r, st, dn);
      check("mul0_res", r, 32'd0);
      check("mul0_stall", st, STALL_MUL0);
      check("mul0_done", dn, 1);

      // Flush at the 10th CALC cycle.
      @(posedge cpu_clk); #1;
      funct3_i  = 3'b101;
      rs1_val_i = 32'd1000;
      rs2_val_i = 32'd3;
      start_i   = 1'b1;
      repeat (11) @(negedge cpu_clk);
      check("flush_pre_stall", {31'd0, stall_o}, 32'd1);
      check("flush_pre_busy",  {31'd0, busy_o},  32'd1);
      flush_i = 1'b1;
      start_i = 1'b0;
      @(posedge cpu_clk); #1;
      flush_i = 1'b0;
      check("flush_busy",  {31'd0, busy_o},  32'd0);
      check("flush_stall", {31'd0, stall_o}, 32'd0);
      late_done = 0;
      repeat (40) begin
         @(negedge cpu_clk);
         if (done_o) late_done++;
      end
      check("flush_no_done", late_done, 0);

      // Flush and start together in IDLE: flush wins.
      @(posedge cpu_clk); #1;
      start_i = 1'b1;
      flush_i = 1'b1;
      #1;
      check("flush_start_stall", {31'd0, stall_o}, 32'd0);
      @(posedge cpu_clk); #1;
      check("flush_start_busy", {31'd0, busy_o}, 32'd0);
      start_i = 1'b0;
      flush_i = 1'b0;

      do_op(3'b101, 32'd100, 32'd7, r, st, dn);
      check("post_flush_res", r, 32'd14);
      check("post_flush_stall", st, 33);

      // Asynchronous reset mid-CALC; result_o holds 14 beforehand.
      @(posedge cpu_clk); #1;
      funct3_i  = 3'b000;
      rs1_val_i = 32'd7;
      rs2_val_i = 32'hFFFF_FFFF;
      start_i   = 1'b1;
      repeat (6) @(negedge cpu_clk);
      check("arst_pre_busy", {31'd0, busy_o}, 32'd1);
      check("arst_pre_result", result_o, 32'd14);
      #2;
      cpu_rst = 1'b1;
      #1;
      check("arst_stall",  {31'd0, stall_o}, 32'd0);
      check("arst_busy",   {31'd0, busy_o},  32'd0);
      check("arst_done",   {31'd0, done_o},  32'd0);
      check("arst_result", result_o, 32'd0);
      start_i = 1'b0;
      @(negedge cpu_clk);
      cpu_rst = 1'b0;

      do_op(3'b111, 32'd100, 32'd7, r, st, dn);
      check("post_rst_res", r, 32'd2);
      check("post_rst_done", dn, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
